// File: rtl/uart_cmd_encoder.sv
// Host-side UART register-access encoder: serialises read/write requests into ASCII
// command frames and parses the ASCII reply into a read-data / error response.
module uart_cmd_encoder #(
    parameter int unsigned          TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [5:0]  i_req_addr,
    input  logic [19:0] i_req_data,
    input  logic        i_uart_idle,
    output logic [7:0]  o_data_tx,
    output logic        o_data_valid,
    input  logic [7:0]  i_uart_data,
    input  logic        i_rx_done,
    output logic        o_rsp_valid,
    output logic [19:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        StIdle, StTxSend, StTxWaitLo, StTxWaitHi, StRxRsp, StDone
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_CYCLES - 1'b1;

    state_e                 state_q, state_d;
    logic                   rw_q, rw_d;
    logic [5:0]             addr_q, addr_d;
    logic [19:0]            data_q, data_d;
    logic [3:0]             idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [19:0]            acc_q, acc_d;
    logic [19:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [7:0]             tx_q;
    logic [7:0]             tx_byte, exp_lit;
    logic                   tx_last, rx_last, rx_is_hex, rx_ok, hex_ok;
    logic [3:0]             hex_val;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            4'd0:    tx_byte = 8'h7B;
            4'd1:    tx_byte = rw_q ? 8'h41 : 8'h61;
            4'd2:    tx_byte = 8'h3A;
            4'd3:    tx_byte = hex_char({2'b00, addr_q[5:4]});
            4'd4:    tx_byte = hex_char(addr_q[3:0]);
            4'd5:    tx_byte = 8'h44;
            4'd6:    tx_byte = 8'h3A;
            4'd7:    tx_byte = hex_char(data_q[19:16]);
            4'd8:    tx_byte = hex_char(data_q[15:12]);
            4'd9:    tx_byte = hex_char(data_q[11:8]);
            4'd10:   tx_byte = hex_char(data_q[7:4]);
            4'd11:   tx_byte = hex_char(data_q[3:0]);
            default: tx_byte = 8'h00;
        endcase
    end

    assign tx_last = rw_q ? (idx_q == 4'd4) : (idx_q == 4'd11);

    // Reply literal: "Read\n" for reads, "Write\n" for writes
    always_comb begin
        exp_lit = 8'h00;
        if (rw_q) begin
            case (idx_q)
                4'd0:    exp_lit = 8'h52;
                4'd1:    exp_lit = 8'h65;
                4'd2:    exp_lit = 8'h61;
                4'd3:    exp_lit = 8'h64;
                4'd4:    exp_lit = 8'h0A;
                default: exp_lit = 8'h00;
            endcase
        end else begin
            case (idx_q)
                4'd0:    exp_lit = 8'h57;
                4'd1:    exp_lit = 8'h72;
                4'd2:    exp_lit = 8'h69;
                4'd3:    exp_lit = 8'h74;
                4'd4:    exp_lit = 8'h65;
                4'd5:    exp_lit = 8'h0A;
                default: exp_lit = 8'h00;
            endcase
        end
    end

    // Low nibble of '0'-'9' is the value; 'A'-'F'/'a'-'f' have low nibble 1-6
    always_comb begin
        hex_ok  = 1'b1;
        hex_val = 4'h0;
        if (i_uart_data >= 8'h30 && i_uart_data <= 8'h39) begin
            hex_val = i_uart_data[3:0];
        end else if ((i_uart_data >= 8'h41 && i_uart_data <= 8'h46) ||
                     (i_uart_data >= 8'h61 && i_uart_data <= 8'h66)) begin
            hex_val = i_uart_data[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
    end

    assign rx_is_hex = rw_q && (idx_q >= 4'd5);
    assign rx_ok     = rx_is_hex ? hex_ok : (i_uart_data == exp_lit);
    assign rx_last   = rw_q ? (idx_q == 4'd9) : (idx_q == 4'd5);

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    rw_d    = i_req_rw;
                    addr_d  = i_req_addr;
                    data_d  = i_req_data;
                    idx_d   = '0;
                    state_d = StTxSend;
                end
            end
            StTxSend: begin
                if (i_uart_idle) state_d = StTxWaitLo;
            end
            StTxWaitLo: begin
                if (!i_uart_idle) state_d = StTxWaitHi;
            end
            StTxWaitHi: begin
                if (i_uart_idle) begin
                    if (tx_last) begin
                        idx_d   = '0;
                        timer_d = '0;
                        acc_d   = '0;
                        state_d = StRxRsp;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StTxSend;
                    end
                end
            end
            StRxRsp: begin
                if (i_rx_done) begin
                    timer_d = '0;
                    if (!rx_ok) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = StDone;
                    end else if (rx_last) begin
                        rsp_err_d  = 1'b0;
                        rsp_data_d = rw_q ? {acc_q[15:0], hex_val} : 20'h0;
                        state_d    = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (rx_is_hex) acc_d = {acc_q[15:0], hex_val};
                    end
                end else if (timer_q == TimeoutLast) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StDone;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            acc_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tx_q       <= '0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if (o_data_valid) tx_q <= tx_byte;
        end
    end

    // Strobe is combinational so the first byte leaves the cycle after acceptance
    assign o_data_valid = (state_q == StTxSend) && i_uart_idle;
    assign o_data_tx    = o_data_valid ? tx_byte : tx_q;
    assign o_req_ready  = (state_q == StIdle);
    assign o_busy       = ~o_req_ready;
    assign o_rsp_valid  = (state_q == StDone);
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_err    = rsp_err_q;

endmodule

// File: doc/uart_cmd_encoder.md
# uart_cmd_encoder

Host-side counterpart of the UART register-access command parser. It accepts a register read/write request on a valid/ready port and serialises it into the ASCII command frame the parser expects. It then parses the parser's ASCII reply and returns the read data, or a completion/error status, on a response port. It sits between a local control master and the UART TX/RX byte engines, so a test FPGA or bridge can drive a remote SPI register bank over a single UART link.

## Interface
- TIMEOUT_W, 24: width of the response timeout counter.
- TIMEOUT_CYCLES, 24'd10_000_000: idle clocks allowed between reply bytes, or between frame end and the first reply byte.
- i_clk_sys  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  encoder can accept a request.
- i_req_rw  in  1  1 = read, 0 = write.
- i_req_addr  in  6  register address.
- i_req_data  in  20  write data (ignored for reads).
- i_uart_idle  in  1  UART TX engine idle.
- o_data_tx  out  8  byte to transmit.
- o_data_valid  out  1  one-cycle transmit strobe.
- i_uart_data  in  8  last received byte.
- i_rx_done  in  1  one-cycle strobe: i_uart_data is a new byte.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_data  out  20  read data; 0 for writes and errors.
- o_rsp_err  out  1  qualifies o_rsp_valid: 1 = malformed reply or timeout.
- o_busy  out  1  transaction in flight (equals ~o_req_ready).

## Operation
- Reset values: o_req_ready=1, o_busy=0, o_data_tx=0, o_data_valid=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
- Reset mid-operation aborts the transaction with no response strobe and returns the block to IDLE.
- States and transitions:
  - IDLE: accept the request when i_req_valid & o_req_ready, latch rw/addr/data, clear the byte index, go to TX_SEND.
  - TX_SEND: wait for i_uart_idle=1, drive the byte, pulse o_data_valid, go to TX_WAIT_LO.
  - TX_WAIT_LO: wait for i_uart_idle=0 (byte taken), go to TX_WAIT_HI.
  - TX_WAIT_HI: wait for i_uart_idle=1. If bytes remain, increment the index and go to TX_SEND. Otherwise clear the index and timer and go to RX_RSP.
  - RX_RSP: check each i_rx_done byte against the expected reply. On the last correct byte, or on any error, go to DONE.
  - DONE: pulse o_rsp_valid for one cycle, then go to IDLE.
- Write frame, 12 bytes: "{", "a", ":", hex(addr[5:4]) as '0'–'3', hex(addr[3:0]), "D", ":", then five hex digits of data, MSB nibble first.
- Read frame, 5 bytes: "{", "A", ":", then the two address digits.
- Transmitted hex digits use '0'–'9' and uppercase 'A'–'F'.
- Expected write reply: exactly "Write\n" (6 bytes). o_rsp_data=0, o_rsp_err=0.
- Expected read reply: "Read\n" followed by 5 hex digits (0–9, A–F, a–f), MSB first. Each digit is shifted left into o_rsp_data 4 bits at a time.
- Any byte that differs from the expected literal, or any non-hex digit, ends the transaction: o_rsp_err=1, o_rsp_data=0.
- i_rx_done bytes received outside RX_RSP are ignored.
- Timeout: the counter resets on RX_RSP entry and on every i_rx_done. When it reaches TIMEOUT_CYCLES-1 without a byte, the response is an error. TX stalls have no timeout.

## Timing
- Request accepted at cycle T: o_req_ready=0 from T+1. The first o_data_valid pulse is at T+1 if i_uart_idle=1.
- o_data_valid is high for exactly one cycle per byte. o_data_tx holds its value until the next byte.
- At most one strobe is issued per idle-low-idle cycle of i_uart_idle. A byte is never re-sent while i_uart_idle stays high after a strobe.
- o_rsp_valid is asserted exactly one cycle after the i_rx_done of the final or offending reply byte, or one cycle after the timeout terminal count.
- o_rsp_data and o_rsp_err are stable from the o_rsp_valid cycle until the next response.
- o_req_ready rises the cycle after o_rsp_valid. A request held valid during that cycle is accepted on the next edge.
- i_req_* are sampled only at acceptance. Changes while busy have no effect.

## Test plan
- Write, addr=6'h2A, data=20'hABCDE, TX model with a 3-cycle busy per byte -> bytes "{a:2AD:ABCDE" in order; reply "Write\n" -> o_rsp_valid with err=0, data=0.
- Read, addr=6'h05 -> bytes "{A:05"; reply "Read\n1f3C9" -> o_rsp_data=20'h1F3C9, err=0.
- Read reply "Reax\n…" -> o_rsp_valid with err=1, data=0 one cycle after the 'x' strobe; o_req_ready returns the next cycle.
- With TIMEOUT_CYCLES=100, read with no reply -> o_rsp_valid, err=1, exactly 100 cycles after RX_RSP entry. A stray i_rx_done received during TX is ignored.
- Hold i_uart_idle high for 10 cycles after a strobe -> no second strobe. Assert i_rst during byte 4 of a write -> all outputs at reset values, no o_rsp_valid, and a new request is accepted after reset.
